// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch redirect controller and its redirect-priority select.
// State and source codes are visible to the commit unit and the testbench.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2,
        HALT   = 2'd3
    } fetch_ctrl_state_t;

    typedef enum logic [1:0] {
        SRC_TRAP = 2'd0,
        SRC_L0   = 2'd1,
        SRC_L1   = 2'd2,
        SRC_L2   = 2'd3
    } redirect_src_t;

    localparam logic [1:0] ST_RUN    = 2'(RUN);
    localparam logic [1:0] ST_FLUSH  = 2'(FLUSH);
    localparam logic [1:0] ST_REFILL = 2'(REFILL);
    localparam logic [1:0] ST_HALT   = 2'(HALT);

    localparam int REFILL_CNT_W = 4;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect request / fetch control bundle between BRAT+commit and the fetch buffer.
// slave = the controller, master = the surrounding pipeline (or a testbench).
interface fetch_redirect_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int RAS_PTR_W  = 3,
    parameter int CNT_WIDTH  = 16
);
    logic                  misprediction_i_0;
    logic                  misprediction_i_1;
    logic                  misprediction_i_2;
    logic [DATA_WIDTH-1:0] correct_pc_i_0;
    logic [DATA_WIDTH-1:0] correct_pc_i_1;
    logic [DATA_WIDTH-1:0] correct_pc_i_2;
    logic [RAS_PTR_W-1:0]  ras_tos_i_0;
    logic [RAS_PTR_W-1:0]  ras_tos_i_1;
    logic [RAS_PTR_W-1:0]  ras_tos_i_2;
    logic                  trap_valid_i;
    logic [DATA_WIDTH-1:0] trap_pc_i;
    logic                  halt_i;

    logic                  flush_o;
    logic                  pc_load_o;
    logic [DATA_WIDTH-1:0] pc_target_o;
    logic                  ras_restore_en_o;
    logic [RAS_PTR_W-1:0]  ras_restore_tos_o;
    logic                  buble_o;
    logic                  decode_hold_o;
    logic [1:0]            state_o;
    logic [CNT_WIDTH-1:0]  mispredict_count_o;

    modport slave (
        input  misprediction_i_0, misprediction_i_1, misprediction_i_2,
        input  correct_pc_i_0, correct_pc_i_1, correct_pc_i_2,
        input  ras_tos_i_0, ras_tos_i_1, ras_tos_i_2,
        input  trap_valid_i, trap_pc_i, halt_i,
        output flush_o, pc_load_o, pc_target_o, ras_restore_en_o,
        output ras_restore_tos_o, buble_o, decode_hold_o, state_o,
        output mispredict_count_o
    );

    modport master (
        output misprediction_i_0, misprediction_i_1, misprediction_i_2,
        output correct_pc_i_0, correct_pc_i_1, correct_pc_i_2,
        output ras_tos_i_0, ras_tos_i_1, ras_tos_i_2,
        output trap_valid_i, trap_pc_i, halt_i,
        input  flush_o, pc_load_o, pc_target_o, ras_restore_en_o,
        input  ras_restore_tos_o, buble_o, decode_hold_o, state_o,
        input  mispredict_count_o
    );

endinterface

// File: rtl/redirect_prio_sel.sv
// Fixed-priority redirect select: trap > lane 0 > lane 1 > lane 2.
// Purely combinational so the commit unit can reuse it.
module redirect_prio_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAS_PTR_W  = 3
) (
    input  logic                  trap_valid_i,
    input  logic [DATA_WIDTH-1:0] trap_pc_i,
    input  logic                  mis_0_i,
    input  logic                  mis_1_i,
    input  logic                  mis_2_i,
    input  logic [DATA_WIDTH-1:0] pc_0_i,
    input  logic [DATA_WIDTH-1:0] pc_1_i,
    input  logic [DATA_WIDTH-1:0] pc_2_i,
    input  logic [RAS_PTR_W-1:0]  tos_0_i,
    input  logic [RAS_PTR_W-1:0]  tos_1_i,
    input  logic [RAS_PTR_W-1:0]  tos_2_i,
    output logic                  valid_o,
    output redirect_src_t         src_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [RAS_PTR_W-1:0]  tos_o
);

    // Pick the oldest redirect; traps carry no RAS checkpoint.
    always_comb begin
        valid_o = 1'b1;
        src_o   = SRC_TRAP;
        pc_o    = '0;
        tos_o   = '0;
        if (trap_valid_i) begin
            src_o = SRC_TRAP;
            pc_o  = trap_pc_i;
        end else if (mis_0_i) begin
            src_o = SRC_L0;
            pc_o  = pc_0_i;
            tos_o = tos_0_i;
        end else if (mis_1_i) begin
            src_o = SRC_L1;
            pc_o  = pc_1_i;
            tos_o = tos_1_i;
        end else if (mis_2_i) begin
            src_o = SRC_L2;
            pc_o  = pc_2_i;
            tos_o = tos_2_i;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer: one flush/PC-load/RAS-restore event per redirect,
// then a fixed decode-hold refill window; halt stalls fetch while no redirect is pending.
module fetch_redirect_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int RAS_PTR_W     = 3,
    parameter int REFILL_CYCLES = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fetch_redirect_ctrl_if.slave  bus
);

    logic                    sel_valid_s;
    redirect_src_t           sel_src_s;
    logic [DATA_WIDTH-1:0]   sel_pc_s;
    logic [RAS_PTR_W-1:0]    sel_tos_s;
    logic                    sel_is_mis_s;

    logic [1:0]              state_d, state_q;
    logic [REFILL_CNT_W-1:0] cnt_d, cnt_q;
    logic                    flush_d, flush_q;
    logic                    ras_en_d, ras_en_q;
    logic [DATA_WIDTH-1:0]   target_d, target_q;
    logic [RAS_PTR_W-1:0]    tos_d, tos_q;
    logic                    buble_d, buble_q;
    logic                    hold_d, hold_q;
    logic [CNT_WIDTH-1:0]    mcnt_d, mcnt_q;

    redirect_prio_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAS_PTR_W  (RAS_PTR_W)
    ) u_sel (
        .trap_valid_i (bus.trap_valid_i),
        .trap_pc_i    (bus.trap_pc_i),
        .mis_0_i      (bus.misprediction_i_0),
        .mis_1_i      (bus.misprediction_i_1),
        .mis_2_i      (bus.misprediction_i_2),
        .pc_0_i       (bus.correct_pc_i_0),
        .pc_1_i       (bus.correct_pc_i_1),
        .pc_2_i       (bus.correct_pc_i_2),
        .tos_0_i      (bus.ras_tos_i_0),
        .tos_1_i      (bus.ras_tos_i_1),
        .tos_2_i      (bus.ras_tos_i_2),
        .valid_o      (sel_valid_s),
        .src_o        (sel_src_s),
        .pc_o         (sel_pc_s),
        .tos_o        (sel_tos_s)
    );

    assign sel_is_mis_s = sel_valid_s && (sel_src_s != SRC_TRAP);

    // Next state and refill counter; a redirect pre-empts every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (sel_valid_s) begin
            state_d = ST_FLUSH;
            cnt_d   = REFILL_CNT_W'(REFILL_CYCLES - 1);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.halt_i) state_d = ST_HALT;
                    else            state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    state_d = ST_REFILL;
                end
                ST_REFILL: begin
                    // FLUSH is the first cycle of the window, so leave on the last count.
                    if (cnt_q <= REFILL_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = bus.halt_i ? ST_HALT : ST_RUN;
                    end else begin
                        cnt_d = cnt_q - REFILL_CNT_W'(1);
                    end
                end
                ST_HALT: begin
                    if (bus.halt_i) state_d = ST_HALT;
                    else            state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output values for the cycle after this edge, derived from the next state.
    always_comb begin
        flush_d  = sel_valid_s;
        ras_en_d = sel_is_mis_s;
        target_d = sel_valid_s  ? sel_pc_s  : target_q;
        tos_d    = sel_is_mis_s ? sel_tos_s : tos_q;
        buble_d  = (state_d == ST_FLUSH) || (state_d == ST_HALT);
        hold_d   = (state_d != ST_RUN);
        if (sel_is_mis_s && (mcnt_q != {CNT_WIDTH{1'b1}})) begin
            mcnt_d = mcnt_q + CNT_WIDTH'(1);
        end else begin
            mcnt_d = mcnt_q;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            cnt_q    <= '0;
            flush_q  <= 1'b0;
            ras_en_q <= 1'b0;
            target_q <= '0;
            tos_q    <= '0;
            buble_q  <= 1'b0;
            hold_q   <= 1'b0;
            mcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            ras_en_q <= ras_en_d;
            target_q <= target_d;
            tos_q    <= tos_d;
            buble_q  <= buble_d;
            hold_q   <= hold_d;
            mcnt_q   <= mcnt_d;
        end
    end

    assign bus.flush_o            = flush_q;
    assign bus.pc_load_o          = flush_q;
    assign bus.pc_target_o        = target_q;
    assign bus.ras_restore_en_o   = ras_en_q;
    assign bus.ras_restore_tos_o  = tos_q;
    assign bus.buble_o            = buble_q;
    assign bus.decode_hold_o      = hold_q;
    assign bus.state_o            = state_q;
    assign bus.mispredict_count_o = mcnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Bench for fetch_redirect_ctrl: directed vector table, random stimulus against a
// window-based reference model, a 2-bit counter instance for saturation, async reset.
module tb_fetch_redirect_ctrl;

    localparam int DW = 32;
    localparam int RW = 3;
    localparam int RC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl_if #(.DATA_WIDTH(DW), .RAS_PTR_W(RW), .CNT_WIDTH(16)) b1 ();
    fetch_redirect_ctrl_if #(.DATA_WIDTH(DW), .RAS_PTR_W(RW), .CNT_WIDTH(2))  b2 ();

    fetch_redirect_ctrl #(.DATA_WIDTH(DW), .RAS_PTR_W(RW), .REFILL_CYCLES(RC), .CNT_WIDTH(16))
        u_dut (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    fetch_redirect_ctrl #(.DATA_WIDTH(DW), .RAS_PTR_W(RW), .REFILL_CYCLES(RC), .CNT_WIDTH(2))
        u_sat (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    assign b2.misprediction_i_0 = b1.misprediction_i_0;
    assign b2.misprediction_i_1 = b1.misprediction_i_1;
    assign b2.misprediction_i_2 = b1.misprediction_i_2;
    assign b2.correct_pc_i_0    = b1.correct_pc_i_0;
    assign b2.correct_pc_i_1    = b1.correct_pc_i_1;
    assign b2.correct_pc_i_2    = b1.correct_pc_i_2;
    assign b2.ras_tos_i_0       = b1.ras_tos_i_0;
    assign b2.ras_tos_i_1       = b1.ras_tos_i_1;
    assign b2.ras_tos_i_2       = b1.ras_tos_i_2;
    assign b2.trap_valid_i      = b1.trap_valid_i;
    assign b2.trap_pc_i         = b1.trap_pc_i;
    assign b2.halt_i            = b1.halt_i;

    // Reference model: a redirect opens an RC-cycle decode-hold window
    int          m_hold;
    logic        m_flush, m_ras_en;
    logic [31:0] m_tgt;
    logic [2:0]  m_tos;
    logic [1:0]  m_state;
    int          m_cnt, m_cnt2;

    typedef struct {
        logic [2:0]  mis;
        logic        trap;
        logic        halt;
        logic [31:0] pc;
        logic [2:0]  tos;
        logic        e_fl;
        logic        e_ras;
        logic [31:0] e_tgt;
        logic [2:0]  e_tos;
        logic [1:0]  e_st;
        logic        e_bub;
        logic        e_hold;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(logic [2:0] mis, logic trap, logic halt, logic [31:0] pc,
                                logic [2:0] tos, logic e_fl, logic e_ras, logic [31:0] e_tgt,
                                logic [2:0] e_tos, logic [1:0] e_st, logic e_bub, logic e_hold,
                                logic [15:0] e_cnt);
        vec_t v;
        v.mis = mis; v.trap = trap; v.halt = halt; v.pc = pc; v.tos = tos;
        v.e_fl = e_fl; v.e_ras = e_ras; v.e_tgt = e_tgt; v.e_tos = e_tos;
        v.e_st = e_st; v.e_bub = e_bub; v.e_hold = e_hold; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic [2:0] mis, logic [31:0] p0, logic [31:0] p1, logic [31:0] p2,
                         logic [2:0] t0, logic [2:0] t1, logic [2:0] t2,
                         logic trap, logic [31:0] tpc, logic halt);
        b1.misprediction_i_0 = mis[0];
        b1.misprediction_i_1 = mis[1];
        b1.misprediction_i_2 = mis[2];
        b1.correct_pc_i_0 = p0; b1.correct_pc_i_1 = p1; b1.correct_pc_i_2 = p2;
        b1.ras_tos_i_0 = t0; b1.ras_tos_i_1 = t1; b1.ras_tos_i_2 = t2;
        b1.trap_valid_i = trap;
        b1.trap_pc_i = tpc;
        b1.halt_i = halt;
    endtask

    task automatic model_reset();
        m_hold = 0; m_flush = 1'b0; m_ras_en = 1'b0; m_tgt = '0; m_tos = '0;
        m_state = 2'd0; m_cnt = 0; m_cnt2 = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic        v [4];
        logic [31:0] p [4];
        logic [2:0]  t [4];
        int          win;
        v[0] = b1.trap_valid_i;      p[0] = b1.trap_pc_i;      t[0] = 3'd0;
        v[1] = b1.misprediction_i_0; p[1] = b1.correct_pc_i_0; t[1] = b1.ras_tos_i_0;
        v[2] = b1.misprediction_i_1; p[2] = b1.correct_pc_i_1; t[2] = b1.ras_tos_i_1;
        v[3] = b1.misprediction_i_2; p[3] = b1.correct_pc_i_2; t[3] = b1.ras_tos_i_2;
        win = -1;
        for (int i = 3; i >= 0; i--) if (v[i]) win = i;
        m_flush  = (win >= 0);
        m_ras_en = (win > 0);
        if (win >= 0) begin
            m_tgt   = p[win];
            m_hold  = RC;
            m_state = 2'd1;
            if (win > 0) begin
                m_tos  = t[win];
                m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
                m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
            end
        end else if (m_hold > 1) begin
            m_hold  = m_hold - 1;
            m_state = 2'd2;
        end else begin
            m_hold  = 0;
            m_state = b1.halt_i ? 2'd3 : 2'd0;
        end
    endtask

    task automatic check_model(string tag);
        logic bub;
        bub = (m_state == 2'd1) || (m_state == 2'd3);
        chk({tag, ".flush"},  32'(b1.flush_o),            32'(m_flush));
        chk({tag, ".pcload"}, 32'(b1.pc_load_o),          32'(m_flush));
        chk({tag, ".target"}, b1.pc_target_o,             m_tgt);
        chk({tag, ".rasen"},  32'(b1.ras_restore_en_o),   32'(m_ras_en));
        chk({tag, ".rastos"}, 32'(b1.ras_restore_tos_o),  32'(m_tos));
        chk({tag, ".buble"},  32'(b1.buble_o),            32'(bub));
        chk({tag, ".hold"},   32'(b1.decode_hold_o),      32'(m_state != 2'd0));
        chk({tag, ".state"},  32'(b1.state_o),            32'(m_state));
        chk({tag, ".cnt"},    32'(b1.mispredict_count_o), 32'(m_cnt));
        chk({tag, ".cnt2"},   32'(b2.mispredict_count_o), 32'(m_cnt2));
    endtask

    task automatic step_model_check(string tag);
        model_step();
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic        h;
        logic [2:0]  mis;
        logic [31:0] lp;
        vec_t        r;

        tbl[0]  = mk(3'b010, 1'b0, 1'b0, 32'h400, 3'd5, 1'b1, 1'b1, 32'h400, 3'd5, 2'd1, 1'b1, 1'b1, 16'd1);
        tbl[1]  = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h400, 3'd5, 2'd2, 1'b0, 1'b1, 16'd1);
        tbl[2]  = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h400, 3'd5, 2'd0, 1'b0, 1'b0, 16'd1);
        tbl[3]  = tbl[2];
        tbl[4]  = mk(3'b101, 1'b1, 1'b0, 32'h100, 3'd1, 1'b1, 1'b0, 32'h100, 3'd5, 2'd1, 1'b1, 1'b1, 16'd1);
        tbl[5]  = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h100, 3'd5, 2'd2, 1'b0, 1'b1, 16'd1);
        tbl[6]  = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h100, 3'd5, 2'd0, 1'b0, 1'b0, 16'd1);
        tbl[7]  = mk(3'b001, 1'b0, 1'b0, 32'h200, 3'd3, 1'b1, 1'b1, 32'h200, 3'd3, 2'd1, 1'b1, 1'b1, 16'd2);
        tbl[8]  = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h200, 3'd3, 2'd2, 1'b0, 1'b1, 16'd2);
        tbl[9]  = mk(3'b100, 1'b0, 1'b0, 32'h300, 3'd6, 1'b1, 1'b1, 32'h300, 3'd6, 2'd1, 1'b1, 1'b1, 16'd3);
        tbl[10] = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h300, 3'd6, 2'd2, 1'b0, 1'b1, 16'd3);
        tbl[11] = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h300, 3'd6, 2'd0, 1'b0, 1'b0, 16'd3);
        for (int i = 12; i < 17; i++)
            tbl[i] = mk(3'b000, 1'b0, 1'b1, 32'h0, 3'd0, 1'b0, 1'b0, 32'h300, 3'd6, 2'd3, 1'b1, 1'b1, 16'd3);
        tbl[17] = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h300, 3'd6, 2'd0, 1'b0, 1'b0, 16'd3);
        tbl[18] = mk(3'b000, 1'b0, 1'b1, 32'h0,   3'd0, 1'b0, 1'b0, 32'h300, 3'd6, 2'd3, 1'b1, 1'b1, 16'd3);
        tbl[19] = mk(3'b010, 1'b0, 1'b1, 32'h480, 3'd7, 1'b1, 1'b1, 32'h480, 3'd7, 2'd1, 1'b1, 1'b1, 16'd4);
        tbl[20] = mk(3'b000, 1'b0, 1'b1, 32'h0,   3'd0, 1'b0, 1'b0, 32'h480, 3'd7, 2'd2, 1'b0, 1'b1, 16'd4);
        tbl[21] = mk(3'b000, 1'b0, 1'b1, 32'h0,   3'd0, 1'b0, 1'b0, 32'h480, 3'd7, 2'd3, 1'b1, 1'b1, 16'd4);
        tbl[22] = mk(3'b000, 1'b0, 1'b0, 32'h0,   3'd0, 1'b0, 1'b0, 32'h480, 3'd7, 2'd0, 1'b0, 1'b0, 16'd4);

        model_reset();
        drive(3'b000, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_model("reset");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            step_model_check("idle");
        end

        // Directed table; a trap row gives the lanes decoy PCs/TOS that must be ignored.
        for (int i = 0; i < 23; i++) begin
            r = tbl[i];
            @(negedge clk);
            lp = r.trap ? (r.pc ^ 32'hFFFF_0000) : r.pc;
            drive(r.mis, lp, lp, lp, r.tos, r.tos, r.tos, r.trap, r.pc, r.halt);
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d.flush", i),  32'(b1.flush_o),            32'(r.e_fl));
            chk($sformatf("tbl%0d.pcload", i), 32'(b1.pc_load_o),          32'(r.e_fl));
            chk($sformatf("tbl%0d.rasen", i),  32'(b1.ras_restore_en_o),   32'(r.e_ras));
            chk($sformatf("tbl%0d.target", i), b1.pc_target_o,             r.e_tgt);
            chk($sformatf("tbl%0d.rastos", i), 32'(b1.ras_restore_tos_o),  32'(r.e_tos));
            chk($sformatf("tbl%0d.state", i),  32'(b1.state_o),            32'(r.e_st));
            chk($sformatf("tbl%0d.buble", i),  32'(b1.buble_o),            32'(r.e_bub));
            chk($sformatf("tbl%0d.hold", i),   32'(b1.decode_hold_o),      32'(r.e_hold));
            chk($sformatf("tbl%0d.cnt", i),    32'(b1.mispredict_count_o), 32'(r.e_cnt));
        end
        chk("sat_cnt_after_table", 32'(b2.mispredict_count_o), 32'd3);

        h = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if ($urandom_range(5) == 0) h = ~h;
            mis[0] = ($urandom_range(7) == 0);
            mis[1] = ($urandom_range(7) == 0);
            mis[2] = ($urandom_range(7) == 0);
            drive(mis, $urandom, $urandom, $urandom, 3'($urandom), 3'($urandom), 3'($urandom),
                  ($urandom_range(15) == 0), $urandom, h);
            step_model_check("rand");
        end

        // Async reset while in REFILL clears everything before the next edge.
        @(negedge clk);
        drive(3'b001, 32'h0000_0A00, 32'h0, 32'h0, 3'd2, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0);
        step_model_check("prerst_flush");
        @(negedge clk);
        drive(3'b000, 32'h0, 32'h0, 32'h0, 3'd0, 3'd0, 3'd0, 1'b0, 32'h0, 1'b0);
        step_model_check("prerst_refill");
        chk("prerst_in_refill", 32'(b1.state_o), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_model("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step_model_check("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
